// File: rtl/iob_native_mem_resp_pkg.sv
// Shared definitions for the native-bus memory responder: bus widths, FSM
// encoding, wait-counter width and the stall LFSR seed/taps.
package iob_native_mem_resp_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    STALL = 2'd3
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/iob_native_mem_resp_lfsr.sv
// Free-running 8-bit LFSR used to inject random response stalls.
// Only built when IOB_NATIVE_MEM_RESP_STALL_EN is defined.
`ifdef IOB_NATIVE_MEM_RESP_STALL_EN
module iob_nresp_lfsr
  import iob_native_mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_r;

  // Advance one step per cycle from the fixed seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign lfsr_o = lfsr_r;

endmodule
`endif

// File: rtl/iob_native_mem_resp.sv
// Native valid/ready memory responder: word RAM with byte strobes and a fixed
// number of wait states. Define IOB_NATIVE_MEM_RESP_STALL_EN for random stalls.
module iob_native_mem_resp
  import iob_native_mem_resp_pkg::*;
#(
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_W      = BUS_DATA_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [1+BUS_ADDR_W+DATA_W+DATA_W/8-1:0] req,
  output logic [DATA_W:0]                         resp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + BUS_ADDR_W + DATA_W + STRB_W;
  localparam int A_LSB  = DATA_W + STRB_W;

  logic                  valid_s;
  logic [MEM_ADDR_W-1:0] req_addr_s;
  logic [DATA_W-1:0]     req_wdata_s;
  logic [STRB_W-1:0]     req_wstrb_s;
  logic                  unused_addr_s;

  assign valid_s       = req[REQ_W-1];
  assign req_addr_s    = req[A_LSB+MEM_ADDR_W+1 : A_LSB+2];
  assign req_wdata_s   = req[A_LSB-1 : STRB_W];
  assign req_wstrb_s   = req[STRB_W-1:0];
  assign unused_addr_s = ^{req[REQ_W-2 : A_LSB+MEM_ADDR_W+2], req[A_LSB+1 : A_LSB]};

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [MEM_ADDR_W-1:0] addr_r, eff_addr_s;
  logic [DATA_W-1:0]     wdata_r, eff_wdata_s;
  logic [STRB_W-1:0]     wstrb_r, eff_wstrb_s;
  logic                  live_r, accept_s, go_resp_s, stall_s, commit_s;
  logic                  ready_r;
  logic [DATA_W-1:0]     rdata_r;
  logic [DATA_W-1:0]     mem_r [2**MEM_ADDR_W];

`ifdef IOB_NATIVE_MEM_RESP_STALL_EN
  logic [7:0] lfsr_s;

  iob_nresp_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr_s)
  );

  assign stall_s = lfsr_s[0];
`else
  assign stall_s = 1'b0;
`endif

  // live_r blocks acceptance (and so RAM writes) while reset is asserted
  assign accept_s = valid_s & live_r;
  assign commit_s = go_resp_s & ~stall_s;

  // Next-state decode; go_resp_s flags a cycle that wants to enter RESP
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    go_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cnt_s = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            go_resp_s = 1'b1;
            state_s   = stall_s ? STALL : RESP;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          go_resp_s = 1'b1;
          state_s   = stall_s ? STALL : RESP;
        end else begin
          state_s = WAIT;
        end
      end
      STALL: begin
        go_resp_s = 1'b1;
        state_s   = stall_s ? STALL : RESP;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Zero-wait commits straight from the bus; otherwise from the latched copy
  always_comb begin
    if (state_r == IDLE) begin
      eff_addr_s  = req_addr_s;
      eff_wdata_s = req_wdata_s;
      eff_wstrb_s = req_wstrb_s;
    end else begin
      eff_addr_s  = addr_r;
      eff_wdata_s = wdata_r;
      eff_wstrb_s = wstrb_r;
    end
  end

  // FSM state, wait counter and request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      live_r  <= 1'b0;
      addr_r  <= {MEM_ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      wstrb_r <= {STRB_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      live_r  <= 1'b1;
      if ((state_r == IDLE) && accept_s) begin
        addr_r  <= req_addr_s;
        wdata_r <= req_wdata_s;
        wstrb_r <= req_wstrb_s;
      end
    end
  end

  // Registered response: one-cycle ready, read data only on read responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      ready_r <= commit_s;
      if (commit_s && (eff_wstrb_s == {STRB_W{1'b0}})) begin
        rdata_r <= mem_r[eff_addr_s];
      end else begin
        rdata_r <= {DATA_W{1'b0}};
      end
    end
  end

  // Byte-lane RAM write on the RESP-entry edge
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (eff_wstrb_s[i]) begin
          mem_r[eff_addr_s][i*8 +: 8] <= eff_wdata_s[i*8 +: 8];
        end
      end
    end
  end

  assign resp = {rdata_r, ready_r};

endmodule

// File: tb/tb_iob_native_mem_resp.sv
// Self-checking bench for iob_native_mem_resp: three instances with
// WAIT_CYCLES = 0, 1 and 3, table vectors, corner sequences, random traffic.
module tb_iob_native_mem_resp;

  logic        clk = 1'b0;
  logic        rst_a [3];
  logic        v_a   [3];
  logic [31:0] ad_a  [3];
  logic [31:0] wd_a  [3];
  logic [3:0]  ws_a  [3];
  logic [68:0] req_a [3];
  logic [32:0] resp_a[3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign req_a[0] = {v_a[0], ad_a[0], wd_a[0], ws_a[0]};
  assign req_a[1] = {v_a[1], ad_a[1], wd_a[1], ws_a[1]};
  assign req_a[2] = {v_a[2], ad_a[2], wd_a[2], ws_a[2]};

  iob_native_mem_resp #(.MEM_ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst_a[0]), .req(req_a[0]), .resp(resp_a[0]));
  iob_native_mem_resp #(.MEM_ADDR_W(10), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst_a[1]), .req(req_a[1]), .resp(resp_a[1]));
  iob_native_mem_resp #(.MEM_ADDR_W(10), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst_a[2]), .req(req_a[2]), .resp(resp_a[2]));

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] ref_mem [int];

`ifdef IOB_NATIVE_MEM_RESP_STALL_EN
  localparam int NRND = 1000;
  localparam int STALL_MAX = 7;
`else
  localparam int NRND = 300;
  localparam int STALL_MAX = 0;
`endif

  function automatic int wc(input int idx);
    case (idx)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its ready pulse
  task automatic txn(input int idx, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input bit keep, input bit b2b, input bit drop,
                     output logic [31:0] rd);
    int lat;
    int lo;
    int hi;
    lat = 0;
    rd  = 32'h0;
    v_a[idx] = 1'b1; ad_a[idx] = addr; wd_a[idx] = wdata; ws_a[idx] = wstrb;
    for (int s = 1; s <= 40 && lat == 0; s++) begin
      @(negedge clk);
      if (resp_a[idx][0] === 1'b1) begin
        lat = s;
        rd  = resp_a[idx][32:1];
      end else begin
        chk("rdata_not_ready", 64'(resp_a[idx][32:1]), 64'h0);
        if (drop && s == 1) begin
          v_a[idx] = 1'b0; ad_a[idx] = ~addr; wd_a[idx] = ~wdata; ws_a[idx] = ~wstrb;
        end
      end
    end
    lo = wc(idx) + 1 + (b2b ? 1 : 0);
    hi = lo + STALL_MAX;
    checks++;
    if (lat < lo || lat > hi) begin
      errors++;
      $display("FAIL latency dut%0d addr 0x%08h: got %0d cycles (0 = none), expected %0d..%0d",
               idx, addr, lat, lo, hi);
    end
    if (!keep) v_a[idx] = 1'b0;
  endtask

  task automatic run(input string name, input int idx, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input bit keep, input bit b2b, input logic [31:0] exp);
    logic [31:0] rd;
    txn(idx, addr, wdata, wstrb, keep, b2b, 1'b0, rd);
    chk(name, 64'(rd), 64'(exp));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, addr, d, exp, cur;
    logic [3:0]  ws;
    bit          keep, prev_keep;
    int          w, key;

    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1; v_a[i] = 1'b0; ad_a[i] = 32'h0; wd_a[i] = 32'h0; ws_a[i] = 4'h0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset_resp", 64'(resp_a[i]), 64'h0);
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    repeat (3) @(negedge clk);

    tbl.push_back('{1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0});
    tbl.push_back('{1, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF});
    tbl.push_back('{1, 32'h0000_0020, 32'h11223344, 4'hF, 32'h0});
    tbl.push_back('{1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'h0});
    tbl.push_back('{1, 32'h0000_0020, 32'h0,        4'h0, 32'h11BB33DD});
    tbl.push_back('{1, 32'h0000_0004, 32'h12345678, 4'hF, 32'h0});
    tbl.push_back('{1, 32'h0000_1004, 32'h0,        4'h0, 32'h12345678});
    tbl.push_back('{1, 32'h0000_0007, 32'h0,        4'h0, 32'h12345678});
    tbl.push_back('{1, 32'hFFFF_F010, 32'h0,        4'h0, 32'hDEADBEEF});
    tbl.push_back('{0, 32'h0000_0000, 32'hA0A0A0A0, 4'hF, 32'h0});
    tbl.push_back('{0, 32'h0000_0004, 32'hB1B1B1B1, 4'hF, 32'h0});
    tbl.push_back('{0, 32'h0000_0008, 32'hC2C2C2C2, 4'hF, 32'h0});

    foreach (tbl[k]) begin
      run("tbl_rdata", tbl[k].idx, tbl[k].addr, tbl[k].wdata, tbl[k].wstrb, 1'b0, 1'b0, tbl[k].exp_rd);
      @(negedge clk);
      chk("tbl_ready_one_cycle", 64'(resp_a[tbl[k].idx][0]), 64'h0);
    end

    // Back-to-back reads with valid held: ready 1, 3 and 5 cycles after first acceptance
    run("b2b_rd0", 0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA0A0A0A0);
    run("b2b_rd4", 0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b1, 32'hB1B1B1B1);
    run("b2b_rd8", 0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC2C2C2C2);
    @(negedge clk);

    // Reset in the middle of a write's wait states drops the write
    run("rst_pre", 2, 32'h30, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    v_a[2] = 1'b1; ad_a[2] = 32'h30; wd_a[2] = 32'hCAFEF00D; ws_a[2] = 4'hF;
    @(negedge clk);
    chk("rst_wait_resp", 64'(resp_a[2]), 64'h0);
    @(negedge clk);
    rst_a[2] = 1'b1;
    #1;
    chk("rst_async_resp", 64'(resp_a[2]), 64'h0);
    @(negedge clk);
    v_a[2] = 1'b0; rst_a[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_no_ready", 64'(resp_a[2]), 64'h0);
    end
    run("rst_read_old", 2, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0, 32'h55AA55AA);
    @(negedge clk);

    // Valid dropped and fields scrambled mid-wait: latched write still completes
    txn(2, 32'h40, 32'h0BADCAFE, 4'hF, 1'b0, 1'b0, 1'b1, rd);
    chk("drop_wr_rdata", 64'(rd), 64'h0);
    @(negedge clk);
    chk("drop_ready_one_cycle", 64'(resp_a[2][0]), 64'h0);
    run("drop_read", 2, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0BADCAFE);
    @(negedge clk);

    // Random traffic on dut1 against a word-array reference model
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      run("rnd_init", 1, 32'h100 + 32'(i * 4), d, 4'hF, 1'b0, 1'b0, 32'h0);
      ref_mem[64 + i] = d;
      @(negedge clk);
    end
    prev_keep = 1'b0;
    for (int n = 0; n < NRND; n++) begin
      w    = int'($urandom_range(0, 15));
      addr = 32'h100 + 32'(w * 4) + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 7)) << 12);
      ws   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d    = $urandom;
      keep = (n != NRND - 1) && ($urandom_range(0, 1) == 1);
      key  = int'((addr >> 2) % 32'd1024);
      if (ws == 4'h0) begin
        exp = ref_mem[key];
      end else begin
        exp = 32'h0;
        cur = ref_mem[key];
        for (int b = 0; b < 4; b++) if (ws[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[key] = cur;
      end
      run("rnd_rdata", 1, addr, d, ws, keep, prev_keep, exp);
      prev_keep = keep;
      if (!keep) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
